// File: rtl/uncached_axi_bridge.sv
// Single-beat AXI master for uncached MEM-stage loads and stores. It stalls the pipeline
// until the transaction finishes, then pulses resp_valid with load data and the error flag.
module uncached_axi_bridge #(
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic            req_wr,
   input  logic            req_uncached,
   input  logic            req_abort,
   input  logic [31:0]     req_addr,
   input  logic [1:0]      req_size,
   input  logic [3:0]      req_wstrb,
   input  logic [31:0]     req_wdata,
   input  logic            flush,
   output logic            stall,
   output logic            resp_valid,
   output logic [31:0]     resp_rdata,
   output logic            resp_err,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [2:0]      arsize,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [2:0]      awsize,
   output logic            awvalid,
   input  logic            awready,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,
   input  logic [ID_W-1:0] bid,
   input  logic [1:0]      bresp,
   input  logic            bvalid,
   output logic            bready
);

   typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;

   state_t      state;
   logic        aw_done, w_done, flush_pend;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic [3:0]  wstrb_q;
   logic        accept, aw_fire, w_fire, busy;
   logic        unused_inputs;

   assign accept  = (state == IDLE) && req_valid && req_uncached && !req_abort && !flush;
   assign busy    = (state != IDLE) && (state != DONE);
   // Combinational so that the accept cycle itself already freezes the pipeline.
   assign stall   = busy || accept;
   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   assign arid   = AXI_ID;
   assign awid   = AXI_ID;
   assign araddr = addr_q;
   assign awaddr = addr_q;
   assign arsize = {1'b0, size_q};
   assign awsize = {1'b0, size_q};
   assign wdata  = wdata_q;
   assign wstrb  = wstrb_q;
   assign wlast  = 1'b1;

   // Single outstanding request, so IDs, rlast and the low response bit carry no information.
   assign unused_inputs = ^{rid, rlast, bid, rresp[0], bresp[0]};

   // NOTE: request registers are only read after a qualified accept, so they need no reset;
   // keeping them out of the async-reset block avoids needless reset fan-out.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= req_addr;
         size_q  <= req_size;
         wstrb_q <= req_wstrb;
         wdata_q <= req_wdata;
      end
   end

   // NOTE: all state and registered outputs use non-blocking assignments so every branch
   // sees the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         awvalid    <= 1'b0;
         wvalid     <= 1'b0;
         bready     <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         flush_pend <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
      end else begin
         resp_valid <= 1'b0;
         if (flush && busy) flush_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (req_wr) begin
                     state   <= WR;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                  end else begin
                     state   <= AR;
                     arvalid <= 1'b1;
                  end
               end
            end
            AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= R;
               end
            end
            R: begin
               if (rvalid) begin
                  rready     <= 1'b0;
                  resp_rdata <= rdata;
                  resp_err   <= rresp[1];
                  resp_valid <= !(flush_pend || flush);
                  state      <= DONE;
               end
            end
            WR: begin
               if (aw_fire) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_fire) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                  bready <= 1'b1;
                  state  <= B;
               end
            end
            B: begin
               if (bvalid) begin
                  bready     <= 1'b0;
                  resp_err   <= bresp[1];
                  resp_valid <= !(flush_pend || flush);
                  state      <= DONE;
               end
            end
            DONE: begin
               flush_pend <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
